// File: rtl/mux4_arb_pkg.sv
// Shared types and helpers for the 4-way round-robin arbiter.
// Optional grant counters are enabled with MUX4_ARB_GNT_CNT_EN.
package mux4_arb_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  localparam int NREQ = 4;
  localparam int IDXW = 2;

  // Mod-4 increment; the 2-bit add wraps 3 -> 0 naturally.
  function automatic logic [IDXW-1:0] nxt_idx(input logic [IDXW-1:0] idx);
    return idx + 2'd1;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin pick: first set req bit searching ptr, ptr+1, ptr+2, ptr+3.
module rr_pick4
  import mux4_arb_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] ptr,
  output logic            any,
  output logic [IDXW-1:0] win,
  output logic [NREQ-1:0] onehot
);

  logic [IDXW-1:0] idx;

  always_comb begin
    any    = 1'b0;
    win    = '0;
    onehot = '0;
    idx    = '0;
    // Scan from farthest to nearest so the closest candidate to ptr is assigned last.
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = ptr + IDXW'(k);
      if (req[idx]) begin
        any = 1'b1;
        win = idx;
      end
    end
    if (any) onehot[win] = 1'b1;
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving a registered 4:1 selector onto a valid/ready output.
// Per-requester grant counters (gnt_cnt) exist only when MUX4_ARB_GNT_CNT_EN is defined.
module mux4_rr_arbiter
  import mux4_arb_pkg::*;
#(
  parameter int DW = 2,
  parameter int CW = 16
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [NREQ-1:0] req,
  input  logic [DW-1:0]   p0,
  input  logic [DW-1:0]   p1,
  input  logic [DW-1:0]   p2,
  input  logic [DW-1:0]   p3,
  output logic [NREQ-1:0] gnt,
  output logic [IDXW-1:0] sel,
  output logic [DW-1:0]   sout,
  output logic            out_valid,
  input  logic            out_ready
`ifdef MUX4_ARB_GNT_CNT_EN
  ,
  output logic [NREQ*CW-1:0] gnt_cnt
`endif
);

  // Handshake: a beat leaves when out_valid && out_ready; a requester's beat is
  // taken in the cycle its gnt bit is high, which happens only when the output
  // register is empty or being drained in that same cycle.

  state_e          state_q, state_d;
  logic [IDXW-1:0] sel_q, sel_d;
  logic [DW-1:0]   sout_q, sout_d;
  logic [IDXW-1:0] ptr_q, ptr_d;

  logic            any;
  logic [IDXW-1:0] win;
  logic [NREQ-1:0] onehot;
  logic            load;
  logic [DW-1:0]   win_data;

  rr_pick4 u_pick (
    .req    (req),
    .ptr    (ptr_q),
    .any    (any),
    .win    (win),
    .onehot (onehot)
  );

  // rstn gates load so no grant is ever issued during a reset cycle.
  assign load = rstn && any && ((state_q == EMPTY) || out_ready);

  always_comb begin
    case (win)
      2'd0:    win_data = p0;
      2'd1:    win_data = p1;
      2'd2:    win_data = p2;
      default: win_data = p3;
    endcase
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    sout_d  = sout_q;
    ptr_d   = ptr_q;
    gnt     = '0;
    if (load) begin
      gnt     = onehot;
      state_d = FULL;
      sel_d   = win;
      sout_d  = win_data;
      ptr_d   = nxt_idx(win);
    end else if ((state_q == FULL) && out_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= EMPTY;
      sel_q   <= '0;
      sout_q  <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      sout_q  <= sout_d;
      ptr_q   <= ptr_d;
    end
  end

  assign sel       = sel_q;
  assign sout      = sout_q;
  assign out_valid = (state_q == FULL);

`ifdef MUX4_ARB_GNT_CNT_EN
  logic [CW-1:0] cnt_q [NREQ];
  logic [CW-1:0] cnt_d [NREQ];

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      cnt_d[i] = cnt_q[i];
      if (gnt[i]) cnt_d[i] = cnt_q[i] + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (!rstn) cnt_q[i] <= '0;
      else       cnt_q[i] <= cnt_d[i];
    end
  end

  for (genvar g = 0; g < NREQ; g++) begin : g_cnt
    assign gnt_cnt[CW*g +: CW] = cnt_q[g];
  end
`endif

endmodule
